// File: rtl/spi_frame_if.sv
// Serial frame link bundle: pins driven by the transmitter, decoded frame fields returned by the receiver.
interface spi_frame_if;
    logic        sck;
    logic        mosi;
    logic        cs_n;
    logic        frame_valid;
    logic        frame_err;
    logic [3:0]  command;
    logic [3:0]  addr;
    logic [11:0] sample;
    logic        busy;
    logic        state_dbg;

    // Strobes are one-cycle pulses with no back-pressure: frame_valid or frame_err
    // fires once per cs_n window and the fields stay stable until the next good frame.
    modport master (
        output sck, mosi, cs_n,
        input  frame_valid, frame_err, command, addr, sample, busy, state_dbg
    );

    modport slave (
        input  sck, mosi, cs_n,
        output frame_valid, frame_err, command, addr, sample, busy, state_dbg
    );
endinterface

// File: rtl/spi_frame_receiver.sv
// Oversampling receiver for the 32-bit serial DAC frame: sync, deserialize, decode fields.
// Optional padding check enabled by defining SPI_FRAME_CHECK_EN.
module spi_frame_receiver #(
    parameter bit LSB_FIRST   = 1'b1,
    parameter int FRAME_BITS  = 32,
    parameter int SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        rst,
    spi_frame_if.slave bus
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_prev;
    logic                   cs_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            sck_prev  <= sck_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sck_s, mosi_s, cs_s;
    logic sck_rise, cs_rise, cs_fall;
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign cs_rise  = cs_s & ~cs_prev;
    assign cs_fall  = ~cs_s & cs_prev;

    logic [0:0]            state;
    logic [FRAME_BITS-1:0] shreg;
    logic [CW-1:0]         count;
    logic                  overrun;
    logic                  frame_valid_r;
    logic                  frame_err_r;
    logic [3:0]            command_r;
    logic [3:0]            addr_r;
    logic [11:0]           sample_r;
    logic                  pad_ok;
    logic                  frame_ok;

`ifdef SPI_FRAME_CHECK_EN
    assign pad_ok = (shreg[31:24] == 8'hFF) && (shreg[3:0] == 4'h0);
`else
    logic unused_pad;
    assign pad_ok     = 1'b1;
    assign unused_pad = ^{shreg[31:24], shreg[3:0]};
`endif

    assign frame_ok = (count == CW'(FRAME_BITS)) && !overrun && pad_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            shreg         <= '0;
            count         <= '0;
            overrun       <= 1'b0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            command_r     <= '0;
            addr_r        <= '0;
            sample_r      <= '0;
        end else begin
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        shreg   <= '0;
                        count   <= '0;
                        overrun <= 1'b0;
                    end
                end
                SHIFT: begin
                    // cs_n rise takes priority; a coincident sck rise is dropped.
                    if (cs_rise) begin
                        state <= IDLE;
                        if (frame_ok) begin
                            command_r     <= shreg[23:20];
                            addr_r        <= shreg[19:16];
                            sample_r      <= shreg[15:4];
                            frame_valid_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        if (count < CW'(FRAME_BITS)) begin
                            if (LSB_FIRST)
                                shreg <= {mosi_s, shreg[FRAME_BITS-1:1]};
                            else
                                shreg <= {shreg[FRAME_BITS-2:0], mosi_s};
                            count <= count + CW'(1);
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.frame_valid = frame_valid_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.command     = command_r;
    assign bus.addr        = addr_r;
    assign bus.sample      = sample_r;
    assign bus.busy        = (state == SHIFT);
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_spi_frame_receiver.sv
// Bench for spi_frame_receiver: LSB-first and MSB-first instances fed the same frames, scoreboard-checked.
module tb_spi_frame_receiver;
    localparam int SYNC_STAGES = 2;
    localparam int W = 22;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sck = 1'b0;
    logic cs_n = 1'b1;
    logic mosi_l = 1'b0;
    logic mosi_m = 1'b0;
    int   cyc = 0;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];
    int           exp_t_q[$];

    logic [3:0]  mdl_cmd = '0;
    logic [3:0]  mdl_addr = '0;
    logic [11:0] mdl_sample = '0;

    spi_frame_if bus_l ();
    spi_frame_if bus_m ();

    assign bus_l.sck  = sck;
    assign bus_l.cs_n = cs_n;
    assign bus_l.mosi = mosi_l;
    assign bus_m.sck  = sck;
    assign bus_m.cs_n = cs_n;
    assign bus_m.mosi = mosi_m;

    spi_frame_receiver #(.LSB_FIRST(1'b1), .FRAME_BITS(32), .SYNC_STAGES(SYNC_STAGES)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    spi_frame_receiver #(.LSB_FIRST(1'b0), .FRAME_BITS(32), .SYNC_STAGES(SYNC_STAGES)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d expected strobes outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_lsb_outputs"}, {bus_l.frame_valid, bus_l.frame_err, bus_l.command, bus_l.addr, bus_l.sample, bus_l.busy}, 0);
        chk({tag, "_msb_outputs"}, {bus_m.frame_valid, bus_m.frame_err, bus_m.command, bus_m.addr, bus_m.sample, bus_m.busy}, 0);
    endtask

    // Reference model: a frame is good iff exactly 32 bits arrived (and, with the check, the padding matches).
    task automatic model_frame(input logic [31:0] word, input int nbits);
        bit good;
        good = (nbits == 32);
`ifdef SPI_FRAME_CHECK_EN
        good = good && (word[31:24] == 8'hFF) && (word[3:0] == 4'h0);
`endif
        if (good) begin
            mdl_cmd    = word[23:20];
            mdl_addr   = word[19:16];
            mdl_sample = word[15:4];
        end
        exp_q.push_back({good, !good, mdl_cmd, mdl_addr, mdl_sample});
        exp_t_q.push_back(cyc + 1 + SYNC_STAGES);
    endtask

    task automatic shift_bits(input logic [31:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            mosi_l = word[i % 32];
            mosi_m = word[31 - (i % 32)];
            wait_cyc($urandom_range(4, 2));
            if (i == 0) begin
                chk("busy_in_frame_lsb", bus_l.busy, 1);
                chk("busy_in_frame_msb", bus_m.busy, 1);
            end
            sck = 1'b1;
            wait_cyc($urandom_range(4, 2));
            sck = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] word, input int nbits, input bit coincident);
        cs_n = 1'b0;
        wait_cyc($urandom_range(4, 2));
        shift_bits(word, nbits);
        wait_cyc($urandom_range(4, 2));
        model_frame(word, nbits);
        if (coincident) sck = 1'b1;
        cs_n = 1'b1;
        wait_cyc($urandom_range(3, 2));
        sck = 1'b0;
        wait_cyc($urandom_range(6, 4));
        chk("busy_after_frame_lsb", bus_l.busy, 0);
        chk("busy_after_frame_msb", bus_m.busy, 0);
    endtask

    // Monitor: every strobe from either instance must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [W-1:0] e;
        int           t;
        if (rst && (bus_l.frame_valid || bus_l.frame_err || bus_m.frame_valid || bus_m.frame_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {bus_l.frame_valid, bus_l.frame_err, bus_m.frame_valid, bus_m.frame_err}, 0);
            end else begin
                e = exp_q.pop_front();
                t = exp_t_q.pop_front();
                chk("frame_lsb", {bus_l.frame_valid, bus_l.frame_err, bus_l.command, bus_l.addr, bus_l.sample}, e);
                chk("frame_msb", {bus_m.frame_valid, bus_m.frame_err, bus_m.command, bus_m.addr, bus_m.sample}, e);
                chk("strobe_latency", cyc, t);
            end
        end
    end

    initial begin
        logic [31:0] word;
        int          nbits;
        int          sel;

        rst = 1'b0;
        wait_cyc(4);
        check_idle("reset");
        rst = 1'b1;
        wait_cyc(4);

        // Directed frames
        send_frame({8'hFF, 4'h3, 4'h0, 12'hABC, 4'h0}, 32, 1'b0);
        send_frame({8'hFF, 4'h5, 4'h6, 12'h123, 4'h0}, 31, 1'b0);
        send_frame({8'hFF, 4'h5, 4'h6, 12'h123, 4'h0}, 33, 1'b0);
        send_frame({8'hFF, 4'h1, 4'h2, 12'h001, 4'h0}, 32, 1'b0);
        send_frame({8'hFE, 4'h7, 4'h8, 12'h456, 4'h0}, 32, 1'b0);
        send_frame({8'hFF, 4'h3, 4'h0, 12'hABC, 4'h0}, 32, 1'b1);

        // Reset mid-frame: partial frame discarded, fields cleared
        cs_n = 1'b0;
        wait_cyc(3);
        shift_bits(32'h5A5A_F00F, 16);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(2);
        cs_n = 1'b1;
        sck  = 1'b0;
        wait_cyc(2);
        rst = 1'b1;
        mdl_cmd    = '0;
        mdl_addr   = '0;
        mdl_sample = '0;
        wait_cyc(8);
        check_idle("mid_reset");
        send_frame({8'hFF, 4'h9, 4'hA, 12'h7E1, 4'h0}, 32, 1'b0);

        // Randomized frames
        for (int n = 0; n < 20; n++) begin
            word = $urandom;
            if ($urandom_range(3, 0) != 0) begin
                word[31:24] = 8'hFF;
                word[3:0]   = 4'h0;
            end
            sel = $urandom_range(7, 0);
            nbits = (sel < 5) ? 32 : (sel == 5) ? 31 : (sel == 6) ? 33 : 0;
            send_frame(word, nbits, 1'($urandom_range(1, 0)));
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) wait_cyc(1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
